// File: rtl/zynet_config_sequencer.sv
// zynet_config_sequencer: streams a flat weight-then-bias word sequence onto
// the zynet core layer/neuron config bus. Each neuron gets a one-cycle SETUP
// phase that publishes its layer/neuron address before any of its data strobes.
module zynet_config_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int L1_NEURONS = 30,
  parameter int L2_NEURONS = 30,
  parameter int L3_NEURONS = 10,
  parameter int L4_NEURONS = 10,
  parameter int L1_WEIGHTS = 784,
  parameter int L2_WEIGHTS = 30,
  parameter int L3_WEIGHTS = 30,
  parameter int L4_WEIGHTS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [31:0]           config_layer_num,
  output logic [31:0]           config_neuron_num,
  output logic                  weight_valid,
  output logic [31:0]           weight_value,
  output logic                  bias_valid,
  output logic [31:0]           bias_value,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, W_SETUP, W_DATA, B_SETUP, B_DATA, DONE} state_t;

  state_t      state;
  logic [2:0]  layer;
  logic [7:0]  neuron;
  logic [9:0]  wcnt;
  logic [7:0]  n_neurons;
  logic [9:0]  n_weights;
  logic        xfer;
  logic        last_weight;
  logic        last_neuron;
  logic        last_layer;
  logic [31:0] word32;

  // Per-layer geometry for the layer currently being walked
  always_comb begin
    n_neurons = '0;
    n_weights = '0;
    case (layer)
      3'd1: begin n_neurons = 8'(L1_NEURONS); n_weights = 10'(L1_WEIGHTS); end
      3'd2: begin n_neurons = 8'(L2_NEURONS); n_weights = 10'(L2_WEIGHTS); end
      3'd3: begin n_neurons = 8'(L3_NEURONS); n_weights = 10'(L3_WEIGHTS); end
      3'd4: begin n_neurons = 8'(L4_NEURONS); n_weights = 10'(L4_WEIGHTS); end
      default: ;
    endcase
  end

  assign xfer        = in_valid & in_ready;
  assign last_weight = (wcnt == n_weights - 10'd1);
  assign last_neuron = (neuron == n_neurons - 8'd1);
  assign last_layer  = (layer == 3'(NUM_LAYERS));
  assign word32      = 32'(in_data);

  // Sequencer FSM with all outputs registered; strobes default low each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      layer             <= '0;
      neuron            <= '0;
      wcnt              <= '0;
      in_ready          <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      weight_valid      <= 1'b0;
      weight_value      <= '0;
      bias_valid        <= 1'b0;
      bias_value        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      bias_valid   <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            layer  <= 3'd1;
            neuron <= '0;
            wcnt   <= '0;
            busy   <= 1'b1;
            state  <= W_SETUP;
          end
        end
        // Address goes out one cycle ahead of the data window
        W_SETUP, B_SETUP: begin
          config_layer_num  <= 32'(layer);
          config_neuron_num <= 32'(neuron);
          in_ready          <= 1'b1;
          state             <= (state == W_SETUP) ? W_DATA : B_DATA;
        end
        W_DATA: begin
          if (xfer) begin
            weight_valid <= 1'b1;
            weight_value <= word32;
            if (last_weight) begin
              wcnt     <= '0;
              in_ready <= 1'b0;
              state    <= W_SETUP;
              if (last_neuron) begin
                neuron <= '0;
                if (last_layer) begin
                  layer <= 3'd1;
                  state <= B_SETUP;
                end else begin
                  layer <= layer + 3'd1;
                end
              end else begin
                neuron <= neuron + 8'd1;
              end
            end else begin
              wcnt <= wcnt + 10'd1;
            end
          end
        end
        B_DATA: begin
          if (xfer) begin
            bias_valid <= 1'b1;
            bias_value <= word32;
            in_ready   <= 1'b0;
            state      <= B_SETUP;
            if (last_neuron) begin
              neuron <= '0;
              if (last_layer) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                layer <= layer + 3'd1;
              end
            end else begin
              neuron <= neuron + 8'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/zynet_config_sequencer.md
Name: zynet_config_sequencer

Overview:
Streaming configuration loader for the zynet network core. It accepts one flat stream of weight and bias words and drives them onto the core's layer/neuron config bus. This replaces the host's per-word AXI-lite sequence of layer select (reg 12), neuron select (reg 16), weight (reg 0) and bias (reg 4). It sits between an AXI-stream/DMA source and the core's config inputs, and is muxed with the AXI-lite path by the core wrapper.

Parameters:
NUM_LAYERS, 4, number of layers configured (1..4)
DATA_WIDTH, 16, significant bits of each config word
L1_NEURONS, 30, neurons in layer 1
L2_NEURONS, 30, neurons in layer 2
L3_NEURONS, 10, neurons in layer 3
L4_NEURONS, 10, neurons in layer 4
L1_WEIGHTS, 784, weights per neuron, layer 1
L2_WEIGHTS, 30, weights per neuron, layer 2
L3_WEIGHTS, 30, weights per neuron, layer 3
L4_WEIGHTS, 10, weights per neuron, layer 4

Ports:
clk  in  1  core clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load from IDLE
in_data  in  DATA_WIDTH  config word stream
in_valid  in  1  stream word valid
in_ready  out  1  sequencer accepts word this cycle
config_layer_num  out  32  layer being configured, 1-based
config_neuron_num  out  32  neuron being configured, 0-based
weight_valid  out  1  one-cycle strobe, weight_value valid
weight_value  out  32  in_data zero-extended to 32 bits
bias_valid  out  1  one-cycle strobe, bias_value valid
bias_value  out  32  in_data zero-extended to 32 bits
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the last bias has been issued

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; config_layer_num = 0; internal counters = 0.
- Stream order: all weights first, then all biases.
  - Weights: for layer 1..NUM_LAYERS, for neuron 0..Ln_NEURONS-1, Ln_WEIGHTS words.
  - Biases: for layer 1..NUM_LAYERS, for neuron 0..Ln_NEURONS-1, one word.
- States: IDLE, W_SETUP, W_DATA, B_SETUP, B_DATA, DONE.
- IDLE:
  - in_ready = 0, busy = 0.
  - start=1 -> W_SETUP; layer index = 1, neuron = 0, weight count = 0; busy = 1 from the next cycle.
- W_SETUP / B_SETUP:
  - Exactly 1 cycle with in_ready = 0.
  - Register config_layer_num and config_neuron_num from the counters, so they are stable ≥1 cycle before that neuron's first strobe.
  - Then go to W_DATA / B_DATA.
- W_DATA:
  - in_ready = 1.
  - Transfer = in_valid & in_ready at edge N -> weight_valid = 1 in cycle N+1 only, weight_value = {zeros, in_data}.
  - Back-to-back transfers give back-to-back strobes. in_valid low gives no strobe and no counter change.
  - On the transfer of the last weight of a neuron: clear the weight count and advance the neuron.
    - If the neuron wraps past Ln_NEURONS-1: neuron = 0, advance the layer.
    - If the layer passes NUM_LAYERS: layer = 1 and go to B_SETUP.
    - Otherwise go to W_SETUP.
  - in_ready drops in the cycle after the last transfer.
- B_DATA:
  - Same handshake as W_DATA; one transfer per neuron; bias_valid/bias_value replace weight_valid/weight_value.
  - After each transfer: advance neuron/layer and go to B_SETUP.
  - After the last bias of the last layer, go to DONE.
- DONE: done = 1 for one cycle, busy = 0 in the same cycle, then IDLE. config_layer_num/config_neuron_num hold their last values.
- start while busy: ignored. start in the DONE cycle: ignored.
- in_valid outside the DATA states: not consumed (in_ready = 0).
- Exactly one of weight_valid and bias_valid is high at a time; never both.
- Layer-parameter lookup uses a case on the layer index. Layers > NUM_LAYERS are never reached.
- Counters are 10 bits (weights) and 8 bits (neurons), zero-extended on the outputs.
- Default total stream: 24820 weights + 80 biases = 24900 words.
- Minimum load time = words + SETUP cycles (one per neuron per pass) + 2.
- rst mid-load: immediate return to IDLE with outputs cleared. A partially loaded core is not repaired; the host must restart.

Test Plan:
- Small config (NUM_LAYERS=2, L1 2 neurons × 3 weights, L2 1 neuron × 2 weights), start, continuous in_valid, words 1..11 -> weight strobes carry 1..8 at (layer,neuron) (1,0)x3, (1,1)x3, (2,0)x2; bias strobes carry 9,10,11 at (1,0), (1,1), (2,0); done once; 11 + 6 setup + 2 cycles from start to done.
- Same config, in_valid toggling every other cycle -> identical strobe values/order; no strobe in cycles without a transfer; in_ready low in every SETUP cycle.
- Check config_neuron_num/config_layer_num -> changed ≥1 cycle before the first strobe of each neuron, never while a strobe is high.
- start pulsed again mid-load and in the DONE cycle -> no restart; counters unaffected; exactly one done pulse.
- rst asserted after word 5 -> busy, in_ready, weight_valid = 0 immediately; new start reloads from (1,0) with word 1.
- Default parameters, 24900 random words -> 24820 weight strobes, 80 bias strobes; final bias at layer 4, neuron 9; done pulses.
